// File: rtl/arb_requester_if.sv
// -----------------------------------------------------------------------------
// arb_requester_if
// Bundles the four-channel requester <-> arbiter/bench signals.
//   push      [3:0] per-channel enqueue strobe (into the requester)
//   GNT       [3:0] fixed-priority arbiter grant (into the requester)
//   REQ       [3:0] registered request to the arbiter
//   done      [3:0] one-cycle completion pulse per channel
//   ovf       [3:0] sticky per-channel overflow flag
//   proto_err       sticky grant-protocol violation flag
//   starve    [3:0] sticky per-channel grant-timeout flag
// Modports: master = requester (drives REQ/status), slave = arbiter/stimulus.
// -----------------------------------------------------------------------------
interface arb_requester_if;
  logic [3:0] push;
  logic [3:0] GNT;
  logic [3:0] REQ;
  logic [3:0] done;
  logic [3:0] ovf;
  logic       proto_err;
  logic [3:0] starve;

  modport master (
    input  push, GNT,
    output REQ, done, ovf, proto_err, starve
  );

  modport slave (
    output push, GNT,
    input  REQ, done, ovf, proto_err, starve
  );
endinterface

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
// Four independent request channels in front of a fixed-priority arbiter.
// Each channel queues up to QDEPTH transactions and, per transaction, holds
// REQ until BURST_LEN granted beats have been received (grants may be
// interrupted by preemption), then emits a one-cycle done pulse.
//
// Parameters: BURST_LEN (1..15), QDEPTH (1..7), TIMEOUT (1..255).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    arb_requester_if.master (push, GNT in; REQ, done, ovf,
//          proto_err, starve out)
// Optional feature: define ARB_REQUESTER_TIMEOUT_EN to build the per-channel
// 8-bit wait-for-grant counter driving starve; otherwise starve is 0.
// -----------------------------------------------------------------------------
module arb_requester #(
  parameter int BURST_LEN = 4,
  parameter int QDEPTH    = 7,
  parameter int TIMEOUT   = 15
) (
  input  logic           clk,
  input  logic           reset,
  arb_requester_if.master bus
);

  localparam int         NCH       = 4;
  localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);
  localparam logic [2:0] QMAX      = 3'(QDEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  state_e         state_q [NCH];
  logic [2:0]     pend_q  [NCH];
  logic [2:0]     pend_d  [NCH];
  logic [3:0]     beat_q  [NCH];
  logic [NCH-1:0] req_q;
  logic [NCH-1:0] done_q;
  logic [NCH-1:0] ovf_q;
  logic [NCH-1:0] ovf_d;
  logic           proto_err_q;
  logic           proto_err_d;
  logic           gnt_multi;
  logic           gnt_unreq;

  // Pending counter: the DONE cycle retires one transaction, so a push in
  // that same cycle nets to zero and can never overflow.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NCH; i++) begin
      pend_d[i] = pend_q[i];
      if (state_q[i] == DONE) begin
        if (!bus.push[i]) pend_d[i] = pend_q[i] - 3'd1;
      end else if (bus.push[i]) begin
        if (pend_q[i] < QMAX) pend_d[i] = pend_q[i] + 3'd1;
        else                  ovf_d[i]  = 1'b1;
      end
    end
  end

  // A power-of-two test catches more than one grant bit set; a grant to a
  // channel whose registered request is low is also a violation.
  always_comb begin
    gnt_multi   = (bus.GNT & (bus.GNT - 4'd1)) != 4'd0;
    gnt_unreq   = (bus.GNT & ~req_q) != 4'd0;
    proto_err_d = proto_err_q | gnt_multi | gnt_unreq;
  end

  // Per-channel FSM; REQ and done are registered alongside the state so
  // REQ is high exactly while the state is ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        pend_q[i]  <= 3'd0;
        beat_q[i]  <= 4'd0;
      end
      req_q       <= '0;
      done_q      <= '0;
      ovf_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      proto_err_q <= proto_err_d;
      for (int i = 0; i < NCH; i++) begin
        pend_q[i] <= pend_d[i];
        done_q[i] <= 1'b0;
        case (state_q[i])
          IDLE: begin
            if (pend_q[i] != 3'd0) begin
              state_q[i] <= ACTIVE;
              req_q[i]   <= 1'b1;
            end else begin
              req_q[i]   <= 1'b0;
            end
          end
          ACTIVE: begin
            // Ungranted cycles (preemption) hold the beat count.
            if (bus.GNT[i]) begin
              if (beat_q[i] == BEAT_LAST) begin
                beat_q[i]  <= 4'd0;
                state_q[i] <= DONE;
                req_q[i]   <= 1'b0;
                done_q[i]  <= 1'b1;
              end else begin
                beat_q[i]  <= beat_q[i] + 4'd1;
              end
            end
          end
          DONE: begin
            // Always pass through IDLE so REQ drops between transactions.
            state_q[i] <= IDLE;
            req_q[i]   <= 1'b0;
          end
          default: begin
            state_q[i] <= IDLE;
            req_q[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.REQ       = req_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.proto_err = proto_err_q;

`ifdef ARB_REQUESTER_TIMEOUT_EN
  localparam logic [7:0] WMAX = 8'(TIMEOUT);

  logic [7:0]     wait_q [NCH];
  logic [NCH-1:0] starve_q;

  // Wait counter counts ungranted ACTIVE cycles and saturates at TIMEOUT;
  // starve latches on the cycle the count reaches TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) wait_q[i] <= 8'd0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (state_q[i] == ACTIVE && !bus.GNT[i]) begin
          if (wait_q[i] < WMAX)         wait_q[i]   <= wait_q[i] + 8'd1;
          if (wait_q[i] >= WMAX - 8'd1) starve_q[i] <= 1'b1;
        end else begin
          wait_q[i] <= 8'd0;
        end
      end
    end
  end

  assign bus.starve = starve_q;
`else
  assign bus.starve = '0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// -----------------------------------------------------------------------------
// tb_arb_requester
// Directed-vector bench for arb_requester with default parameters
// (BURST_LEN=4, QDEPTH=7, TIMEOUT=15). Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_arb_requester;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errs;

  arb_requester_if bus ();

  arb_requester #(
    .BURST_LEN(4),
    .QDEPTH   (7),
    .TIMEOUT  (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] gsched [8];
  int hi_cnt, done_cnt, d3_at, d0_at;

  initial begin
    n_checks  = 0;
    n_errs    = 0;
    reset     = 1'b1;
    bus.push  = 4'b0000;
    bus.GNT   = 4'b0000;
    tick();
    tick();
    // Reset state
    check_eq("rst_req",    bus.REQ, 4'b0000);
    check_eq("rst_done",   bus.done, 4'b0000);
    check_eq("rst_ovf",    bus.ovf, 4'b0000);
    check_eq("rst_perr",   bus.proto_err, 1'b0);
    check_eq("rst_starve", bus.starve, 4'b0000);
    check_eq("rst_pend0",  dut.pend_q[0], 3'd0);
    reset = 1'b0;
    tick();

    // Single transaction on ch0 with auto-grant
    bus.push = 4'b0001;
    tick();
    bus.push = 4'b0000;
    check_eq("single_req_lat1", bus.REQ, 4'b0000);
    tick();
    check_eq("single_req_lat2", bus.REQ, 4'b0001);
    hi_cnt   = 0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.REQ[0])  hi_cnt++;
      if (bus.done[0]) done_cnt++;
      bus.GNT = bus.REQ & 4'b0001;
      tick();
    end
    bus.GNT = 4'b0000;
    check_eq("single_req_cycles", hi_cnt, 4);
    check_eq("single_done_pulses", done_cnt, 1);
    check_eq("single_pend0", dut.pend_q[0], 3'd0);
    check_eq("single_perr", bus.proto_err, 1'b0);

    // Preemption: ch0 2 beats, ch3 4 beats, ch0 2 beats
    bus.push = 4'b1001;
    tick();
    bus.push = 4'b0000;
    tick();
    check_eq("pre_req", bus.REQ, 4'b1001);
    gsched[0] = 4'b0001; gsched[1] = 4'b0001;
    gsched[2] = 4'b1000; gsched[3] = 4'b1000;
    gsched[4] = 4'b1000; gsched[5] = 4'b1000;
    gsched[6] = 4'b0001; gsched[7] = 4'b0001;
    d3_at = -1;
    d0_at = -1;
    for (int k = 0; k < 10; k++) begin
      bus.GNT = (k < 8) ? gsched[k] : 4'b0000;
      tick();
      if (bus.done[3]) d3_at = k;
      if (bus.done[0]) d0_at = k;
    end
    bus.GNT = 4'b0000;
    check_eq("pre_done3_at", d3_at, 5);
    check_eq("pre_done0_at", d0_at, 7);
    check_eq("pre_req_end", bus.REQ, 4'b0000);
    check_eq("pre_pend0", dut.pend_q[0], 3'd0);
    check_eq("pre_pend3", dut.pend_q[3], 3'd0);
    check_eq("pre_perr", bus.proto_err, 1'b0);

    // Overflow: 8 back-to-back pushes on ch2, no grants
    bus.push = 4'b0100;
    for (int k = 0; k < 7; k++) tick();
    check_eq("ovf_before", bus.ovf, 4'b0000);
    check_eq("ovf_pend_full", dut.pend_q[2], 3'd7);
    tick();
    bus.push = 4'b0000;
    check_eq("ovf_pend2", dut.pend_q[2], 3'd7);
    check_eq("ovf_flag", bus.ovf, 4'b0100);

    // Complete one ch2 burst; push at QDEPTH during DONE is accepted
    bus.GNT = 4'b0100;
    for (int k = 0; k < 4; k++) tick();
    bus.GNT  = 4'b0000;
    check_eq("full_done2", bus.done, 4'b0100);
    check_eq("full_req_done", bus.REQ, 4'b0000);
    bus.push = 4'b0100;
    tick();
    bus.push = 4'b0000;
    check_eq("full_pend_kept", dut.pend_q[2], 3'd7);
    check_eq("full_req_idle", bus.REQ, 4'b0000);
    check_eq("full_done_off", bus.done, 4'b0000);
    tick();
    check_eq("full_req_again", bus.REQ, 4'b0100);
    check_eq("full_ovf_sticky", bus.ovf, 4'b0100);

    // Protocol: two grant bits at once
    check_eq("perr_before", bus.proto_err, 1'b0);
    bus.GNT = 4'b0110;
    tick();
    bus.GNT = 4'b0000;
    tick();
    tick();
    check_eq("perr_multi_held", bus.proto_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("perr_cleared", bus.proto_err, 1'b0);
    check_eq("ovf_cleared", bus.ovf, 4'b0000);
    check_eq("req_cleared", bus.REQ, 4'b0000);
    // Protocol: grant with no request
    bus.GNT = 4'b0100;
    tick();
    bus.GNT = 4'b0000;
    tick();
    check_eq("perr_unreq_held", bus.proto_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset mid-burst on ch1 after 2 beats; push during reset ignored
    bus.push = 4'b0010;
    tick();
    bus.push = 4'b0000;
    tick();
    check_eq("mid_req", bus.REQ, 4'b0010);
    bus.GNT = 4'b0010;
    tick();
    tick();
    bus.GNT  = 4'b0000;
    reset    = 1'b1;
    bus.push = 4'b0010;
    tick();
    reset    = 1'b0;
    bus.push = 4'b0000;
    check_eq("mid_rst_req", bus.REQ, 4'b0000);
    check_eq("mid_rst_pend1", dut.pend_q[1], 3'd0);
    check_eq("mid_rst_flags", {bus.ovf, bus.proto_err, bus.starve}, 9'd0);
    done_cnt = 0;
    hi_cnt   = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.done != 4'b0000) done_cnt++;
      if (bus.REQ  != 4'b0000) hi_cnt++;
    end
    check_eq("mid_no_done", done_cnt, 0);
    check_eq("mid_no_restart", hi_cnt, 0);

    // Timeout on ch0: 15 ungranted ACTIVE cycles
    bus.push = 4'b0001;
    tick();
    bus.push = 4'b0000;
    tick();
    check_eq("to_req", bus.REQ, 4'b0001);
    for (int k = 0; k < 14; k++) tick();
    check_eq("to_starve_14", bus.starve, 4'b0000);
    tick();
`ifdef ARB_REQUESTER_TIMEOUT_EN
    check_eq("to_starve_15", bus.starve, 4'b0001);
`else
    check_eq("to_starve_15", bus.starve, 4'b0000);
`endif
    bus.GNT = 4'b0001;
    tick();
    bus.GNT = 4'b0000;
`ifdef ARB_REQUESTER_TIMEOUT_EN
    check_eq("to_starve_sticky", bus.starve, 4'b0001);
`else
    check_eq("to_starve_sticky", bus.starve, 4'b0000);
`endif
    check_eq("to_perr", bus.proto_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
